log_pre_process: RTL and testbench

Front end of the log datapath. Accepts an IEEE-754 single-precision operand and produces two values for the log-core: the fixed-point exponent term (unbiased exponent × ln2) and the normalized mantissa. Denormal inputs are normalized with a leading-zero count. Special operands are classified. The block is a 2-stage valid/ready pipeline whose output format matches what the log post-processing stage expects for exp_part and man_part.

---
 rtl/log_pre_process.sv | 92 +++++++++
 tb/tb_log_pre_process.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/log_pre_process.sv
// log_pre_process: unpacks an IEEE-754 single into exponent*ln2 and normalized mantissa for the log core
module log_pre_process #(
    parameter logic [27:0] LN2_Q28 = 28'd186065280,
    parameter int          EXP_W   = 38,
    parameter int          MAN_W   = 25
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             float_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [EXP_W-1:0] exp_part,
    output logic [MAN_W-1:0]        man_part,
    output logic [1:0]              out_class
);
    logic        s1_valid;
    logic [8:0]  s1_e;
    logic [23:0] s1_m;
    logic [1:0]  s1_class;
    logic        s1_adv;
    logic        s2_adv;
    logic [8:0]  e_d;
    logic [23:0] m_d;
    logic [1:0]  class_d;
    logic [4:0]  lz;
    logic [31:0] x;
    logic signed [EXP_W-1:0] prod;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign prod     = EXP_W'($signed(s1_e)) * $signed(EXP_W'(LN2_Q28));

    // Classify the operand and normalize denormals; x ends with its leading one at bit 31
    always_comb begin
        x       = {float_in[22:0], 9'd0};
        lz      = '0;
        lz[4]   = (x[31:16] == 16'd0);
        x       = lz[4] ? x << 16 : x;
        lz[3]   = (x[31:24] == 8'd0);
        x       = lz[3] ? x << 8 : x;
        lz[2]   = (x[31:28] == 4'd0);
        x       = lz[2] ? x << 4 : x;
        lz[1]   = (x[31:30] == 2'd0);
        x       = lz[1] ? x << 2 : x;
        lz[0]   = !x[31];
        x       = lz[0] ? x << 1 : x;
        class_d = (float_in[30:23] == 8'hFF) ? ((float_in[22:0] != 23'd0 || float_in[31]) ? 2'b10 : 2'b11) :
                  (float_in[30:0] == 31'd0) ? 2'b01 :
                  float_in[31] ? 2'b10 : 2'b00;
        e_d     = (class_d != 2'b00) ? 9'd0 :
                  (float_in[30:23] != 8'd0) ? {1'b0, float_in[30:23]} - 9'd127 : 9'h181 - {4'd0, lz};
        m_d     = (class_d != 2'b00) ? 24'd0 :
                  (float_in[30:23] != 8'd0) ? {1'b1, float_in[22:0]} : {1'b1, x[30:8]};
    end

    // Stage 1: capture classified operand when the stage can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_e     <= '0;
            s1_m     <= '0;
            s1_class <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_e     <= e_d;
                s1_m     <= m_d;
                s1_class <= class_d;
            end
        end
    end

    // Stage 2: scale exponent by ln2 and hold outputs until downstream accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            exp_part  <= '0;
            man_part  <= '0;
            out_class <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                exp_part  <= prod;
                man_part  <= MAN_W'({1'b0, s1_m});
                out_class <= s1_class;
            end
        end
    end
endmodule

// File: tb/tb_log_pre_process.sv
// tb_log_pre_process: directed vectors checked against a float-level model of the pre-processor
module tb_log_pre_process;
    typedef struct packed {
        logic signed [37:0] ex;
        logic [24:0]        mn;
        logic [1:0]         cl;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       float_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [37:0] exp_part;
    logic [24:0]       man_part;
    logic [1:0]        out_class;

    int   vectors = 0;
    int   miscompares = 0;
    res_t q[$];
    res_t held_r;
    logic held = 1'b0;
    res_t r;

    log_pre_process dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .float_in(float_in), .out_valid(out_valid), .out_ready(out_ready),
        .exp_part(exp_part), .man_part(man_part), .out_class(out_class)
    );

    always #5 clk = ~clk;

    // value-level model: log(x) = e*ln2 + log(m), with x = m * 2^e, 1 <= m < 2
    function automatic res_t model(input logic [31:0] v);
        res_t o;
        int be, p, ee;
        longint f, mm;
        o  = '0;
        be = int'(v[30:23]);
        f  = longint'(v[22:0]);
        if (be == 255) o.cl = (f == 0 && !v[31]) ? 2'd3 : 2'd2;
        else if (be == 0 && f == 0) o.cl = 2'd1;
        else if (v[31]) o.cl = 2'd2;
        else begin
            if (be != 0) begin
                ee = be - 127;
                mm = f + 64'd8388608;
            end else begin
                p = 22;
                while (((f >> p) & 1) == 0) p--;
                ee = p - 149;
                mm = (f << (23 - p)) & 64'hFFFFFF;
            end
            o.ex = 38'(longint'(ee) * longint'(186065280));
            o.mn = 25'(mm);
        end
        return o;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] v);
        int n = 0;
        in_valid = 1'b1;
        float_in = v;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: record accepted inputs, compare every emitted output and every stalled hold
    always @(negedge clk) begin
        if (!rst_n) held = 1'b0;
        else begin
            if (held) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_data", longint'(exp_part) ^ longint'({man_part, out_class}),
                    longint'(held_r.ex) ^ longint'({held_r.mn, held_r.cl}));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", longint'(out_valid), 0);
                else begin
                    r = q.pop_front();
                    chk("exp_part", longint'(exp_part), longint'(r.ex));
                    chk("man_part", longint'(man_part), longint'(r.mn));
                    chk("out_class", longint'(out_class), longint'(r.cl));
                end
            end
            held   = out_valid && !out_ready;
            held_r = '{exp_part, man_part, out_class};
            if (in_valid && in_ready) q.push_back(model(float_in));
        end
    end

    initial begin
        int n;
        res_t m;
        rst_n = 1'b0; in_valid = 1'b0; float_in = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_exp_part", longint'(exp_part), 0);
        chk("rst_man_part", longint'(man_part), 0);
        chk("rst_class", longint'(out_class), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("idle_in_ready", longint'(in_ready), 1);
        m = model(32'h41000000); chk("model_8p0", longint'(m.ex), 558195840);
        m = model(32'h3F000000); chk("model_0p5", longint'(m.ex), -186065280);
        m = model(32'h00400000); chk("model_den_hi", longint'(m.ex), -64'sd23630290560);
        chk("model_den_hi_m", longint'(m.mn), 25'h0800000);
        m = model(32'h00000001); chk("model_den_lo", longint'(m.ex), -64'sd27723726720);
        m = model(32'h7F800000); chk("model_inf", longint'(m.cl), 3);
        // 1.0: two-cycle latency with literal outputs
        send(32'h3F800000);
        in_valid = 1'b0;
        @(negedge clk); chk("lat_not_yet", longint'(out_valid), 0);
        @(negedge clk);
        chk("lat_valid", longint'(out_valid), 1);
        chk("one_exp", longint'(exp_part), 0);
        chk("one_man", longint'(man_part), 25'h0800000);
        chk("one_class", longint'(out_class), 0);
        idle(2);
        // back-to-back with full throughput
        send(32'h41000000);
        chk("b2b_ready", longint'(in_ready), 1);
        send(32'h3F000000);
        chk("b2b_ready2", longint'(in_ready), 1);
        idle(3);
        // denormals and specials, streamed
        send(32'h00400000); send(32'h00000001); send(32'h00012345);
        send(32'h00000000); send(32'h80000000); send(32'hC0000000);
        send(32'h7F800000); send(32'h7FC00000); send(32'hFF800000); send(32'h7F7FFFFF);
        idle(4);
        // backpressure: two ops fill the pipe, third waits
        out_ready = 1'b0;
        send(32'h40400000); send(32'h3E800000);
        in_valid = 1'b1; float_in = 32'h42C80000;
        @(negedge clk); chk("bp_in_ready", longint'(in_ready), 0);
        repeat (3) @(negedge clk);
        chk("bp_full_valid", longint'(out_valid), 1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        idle(4);
        // asynchronous reset with two ops in flight
        send(32'h40000000); send(32'h40800000);
        in_valid = 1'b0;
        #1 chk("pre_rst_valid", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_exp", longint'(exp_part), 0);
        chk("mid_rst_man", longint'(man_part), 0);
        chk("mid_rst_class", longint'(out_class), 0);
        q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        idle(8);
        send(32'h3FC00000);
        idle(1);
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", longint'(q.size()), 0);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
